// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: the raw keypad lines on one side and the
// accepted-key outputs towards the calculator core on the other.
// The scanner takes the master modport; the keypad/consumer side takes slave.
interface keypad_scanner_if;
    logic [3:0] RowIn;
    logic [3:0] ColOut;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  RowIn,
        output ColOut,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output RowIn,
        input  ColOut,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Drives one column low at a time, synchronises the rows, rejects multi-key
// patterns and bounce, and emits one key code plus a one-cycle strobe per press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
// Rows reach the FSM three edges after they change (two synchroniser flops
// plus the registered decision), so SCAN_DIV should cover that latency.
module keypad_scanner #(
    parameter int SCAN_DIV     = 2500,
    parameter int DEBOUNCE_CNT = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic             clk,
    input  logic             nRST,
    keypad_scanner_if.master kp
);

    localparam int SLOT_W = $clog2(SCAN_DIV) + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        SCAN,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        sync1;
    logic [3:0]        rs;
    logic [SLOT_W-1:0] slot_cnt;
    logic [DB_W-1:0]   db_cnt;
    logic [3:0]        col_drive;
    logic [3:0]        row_pat;
    logic [3:0]        key_code_q;
    logic              key_valid_q;

    logic slot_last;
    logic db_done;
    logic one_low;
    logic rows_idle;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_started;
    logic             rep_hit;

    assign rep_hit = (rep_cnt == (rep_started ? REP_RATE_LAST : REP_DELAY_LAST));
`endif

    // Position of the single low bit in an active-low one-cold pattern.
    function automatic logic [1:0] low_index(input logic [3:0] pat);
        case (pat)
            4'b1110: low_index = 2'd0;
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    // Keypad legend: * reports as E and # as F.
    function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'b00_00: decode_key = 4'h1;
            4'b00_01: decode_key = 4'h2;
            4'b00_10: decode_key = 4'h3;
            4'b00_11: decode_key = 4'hA;
            4'b01_00: decode_key = 4'h4;
            4'b01_01: decode_key = 4'h5;
            4'b01_10: decode_key = 4'h6;
            4'b01_11: decode_key = 4'hB;
            4'b10_00: decode_key = 4'h7;
            4'b10_01: decode_key = 4'h8;
            4'b10_10: decode_key = 4'h9;
            4'b10_11: decode_key = 4'hC;
            4'b11_00: decode_key = 4'hE;
            4'b11_01: decode_key = 4'h0;
            4'b11_10: decode_key = 4'hF;
            default:  decode_key = 4'hD;
        endcase
    endfunction

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign db_done   = (db_cnt == DB_LAST);
    assign rows_idle = (rs == 4'b1111);
    assign one_low   = (rs == 4'b1110) || (rs == 4'b1101) || (rs == 4'b1011) || (rs == 4'b0111);

    // Bring the asynchronous row lines into the clock domain.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            sync1 <= 4'b1111;
            rs    <= 4'b1111;
        end else begin
            sync1 <= kp.RowIn;
            rs    <= sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state <= SCAN;
        end else begin
            state <= next_state;
        end
    end

    // FSM transitions: scan, debounce the press, hold, debounce the release.
    always_comb begin
        next_state = state;
        case (state)
            SCAN: begin
                if (slot_last && one_low) begin
                    next_state = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (rs != row_pat) begin
                    next_state = SCAN;
                end else if (db_done) begin
                    next_state = HELD;
                end
            end
            HELD: begin
                if (rows_idle) begin
                    next_state = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (!rows_idle) begin
                    next_state = HELD;
                end else if (db_done) begin
                    next_state = SCAN;
                end
            end
            default: next_state = SCAN;
        endcase
    end

    // Counters, column drive, captured pattern and the registered key outputs.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            slot_cnt    <= '0;
            db_cnt      <= '0;
            col_drive   <= 4'b1110;
            row_pat     <= 4'b1111;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
            rep_started <= 1'b0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            case (state)
                SCAN: begin
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt     <= '0;
                    rep_started <= 1'b0;
`endif
                    if (slot_last) begin
                        slot_cnt <= '0;
                        if (one_low) begin
                            row_pat <= rs;
                            db_cnt  <= '0;
                        end else begin
                            col_drive <= {col_drive[2:0], col_drive[3]};
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                DB_PRESS: begin
                    if (rs != row_pat) begin
                        slot_cnt <= '0;
                    end else if (db_done) begin
                        key_code_q  <= decode_key(low_index(row_pat), low_index(col_drive));
                        key_valid_q <= 1'b1;
                        db_cnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt     <= '0;
                        rep_started <= 1'b0;
`endif
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (rows_idle) begin
                        db_cnt <= '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (rep_hit) begin
                        key_valid_q <= 1'b1;
                        rep_cnt     <= '0;
                        rep_started <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                DB_RELEASE: begin
                    if (rows_idle) begin
                        if (db_done) begin
                            col_drive <= {col_drive[2:0], col_drive[3]};
                            slot_cnt  <= '0;
                            db_cnt    <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Drive the bundle outputs; a key counts as held until its release is accepted.
    always_comb begin
        kp.ColOut    = col_drive;
        kp.key_code  = key_code_q;
        kp.key_valid = key_valid_q;
        kp.key_held  = (state == HELD) || (state == DB_RELEASE);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad model: a pressed key
// pulls its row low only while its column is driven low.
// Outputs are sampled on the falling edge; indices count falling edges.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int REPEAT_DELAY = 40;
    localparam int REPEAT_RATE  = 16;

    logic        clk  = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] pressed = '0;
    logic [3:0]  row_lines;
    logic [3:0]  exp_col;

    int compared   = 0;
    int mismatched = 0;

    int         first;
    int         count;
    logic [3:0] code_at;
    logic [3:0] col_at;
    logic       held_at;
    logic       held10;
    logic       held11;
    logic [3:0] col11;
    int         strobes;
    logic       saw_c1;
    int         offs  [8];
    logic [3:0] codes [8];
    int         exp_n;
    int         exp_offs [5];

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk (clk),
        .nRST(nRST),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Keypad matrix: row r goes low when a pressed key (r,c) sees its column low.
    always_comb begin
        row_lines = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kp.ColOut[c]) begin
                    row_lines[r] = 1'b0;
                end
            end
        end
    end

    assign kp.RowIn = row_lines;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input int c, input logic down);
        pressed[r*4+c] = down;
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target);
        for (int i = 0; i < 40 && kp.ColOut !== target; i++) @(negedge clk);
        checkOutput(tag, {28'd0, kp.ColOut}, {28'd0, target});
    endtask

    task automatic release_key(input string tag, input int r, input int c);
        applyStimulus(r, c, 1'b0);
        for (int i = 0; i < 40 && kp.key_held; i++) @(negedge clk);
        checkOutput(tag, {31'd0, kp.key_held}, 32'd0);
    endtask

    task automatic measure(input int cycles, output int f, output int n,
                           output logic [3:0] code, output logic [3:0] col, output logic held);
        f = -1; n = 0; code = 4'h0; col = 4'h0; held = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (kp.key_valid) begin
                if (f < 0) begin
                    f = i; code = kp.key_code; col = kp.ColOut; held = kp.key_held;
                end
                n++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values, then free scanning with every column lasting 4 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ColOut", {28'd0, kp.ColOut}, 32'hE);
        checkOutput("reset key_code", {28'd0, kp.key_code}, 32'd0);
        checkOutput("reset key_valid", {31'd0, kp.key_valid}, 32'd0);
        checkOutput("reset key_held", {31'd0, kp.key_held}, 32'd0);
        nRST = 1'b1;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            exp_col = 4'b1110;
            for (int k = 0; k < (i / 4) % 4; k++) exp_col = {exp_col[2:0], exp_col[3]};
            if (i % 4 == 0 || i % 4 == 3)
                checkOutput($sformatf("scan ColOut idx %0d", i), {28'd0, kp.ColOut}, {28'd0, exp_col});
            if (kp.key_valid) strobes++;
            @(negedge clk);
        end
        checkOutput("idle strobes", strobes, 0);

        // Key 6 (r1,c2): column reached at T0, detect at T4, 8 matches -> strobe at idx 12.
        wait_col("t2 pre", 4'b1110);
        applyStimulus(1, 2, 1'b1);
        wait_col("t2 col c2", 4'b1011);
        measure(31, first, count, code_at, col_at, held_at);
        checkOutput("t2 strobe idx", first, 12);
        checkOutput("t2 strobe count", count, 1);
        checkOutput("t2 key_code", {28'd0, code_at}, 32'h6);
        checkOutput("t2 ColOut frozen", {28'd0, col_at}, 32'hB);
        checkOutput("t2 key_held", {31'd0, held_at}, 32'd1);
        // Release: rows idle seen at R3, 8 idle matches -> held drops at idx 11.
        applyStimulus(1, 2, 1'b0);
        held10 = 1'b0; held11 = 1'b1; col11 = 4'h0; strobes = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 10) held10 = kp.key_held;
            if (k == 11) begin held11 = kp.key_held; col11 = kp.ColOut; end
            if (kp.key_valid) strobes++;
            if (k < 11) @(negedge clk);
        end
        checkOutput("t2 held before release accepted", {31'd0, held10}, 32'd1);
        checkOutput("t2 held after release accepted", {31'd0, held11}, 32'd0);
        checkOutput("t2 ColOut after release", {28'd0, col11}, 32'h7);
        checkOutput("t2 release strobes", strobes, 0);

        // Bounce on key 2 (r0,c1): low 5, high 1, low again -> strobe at idx 20.
        wait_col("t3 pre", 4'b0111);
        applyStimulus(0, 1, 1'b1);
        wait_col("t3 col c1", 4'b1101);
        first = -1; count = 0; code_at = 4'h0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) applyStimulus(0, 1, 1'b0);
            if (i == 6) applyStimulus(0, 1, 1'b1);
            if (kp.key_valid) begin
                if (first < 0) begin first = i; code_at = kp.key_code; end
                count++;
            end
            @(negedge clk);
        end
        checkOutput("t3 strobe idx", first, 20);
        checkOutput("t3 strobe count", count, 1);
        checkOutput("t3 key_code", {28'd0, code_at}, 32'h2);
        release_key("t3 release", 0, 1);

        // Two rows low in column 0 (rows 1100): keep scanning, no strobe.
        wait_col("t4 pre", 4'b1011);
        applyStimulus(0, 0, 1'b1);
        applyStimulus(1, 0, 1'b1);
        wait_col("t4 col c0", 4'b1110);
        strobes = 0; saw_c1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (kp.key_valid) strobes++;
            if (kp.ColOut == 4'b1101) saw_c1 = 1'b1;
            @(negedge clk);
        end
        checkOutput("t4 multi-key strobes", strobes, 0);
        checkOutput("t4 scanning continued", {31'd0, saw_c1}, 32'd1);
        applyStimulus(0, 0, 1'b0);
        applyStimulus(1, 0, 1'b0);
        // Key D (r3,c3) alone.
        wait_col("t4 pre2", 4'b1110);
        applyStimulus(3, 3, 1'b1);
        wait_col("t4 col c3", 4'b0111);
        measure(30, first, count, code_at, col_at, held_at);
        checkOutput("t4 strobe idx", first, 12);
        checkOutput("t4 key_code", {28'd0, code_at}, 32'hD);
        release_key("t4 release", 3, 3);

        // Reset in the middle of the press debounce of key 9 (r2,c2).
        wait_col("t5 pre", 4'b1110);
        applyStimulus(2, 2, 1'b1);
        wait_col("t5 col c2", 4'b1011);
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            if (kp.key_valid) strobes++;
            @(negedge clk);
        end
        nRST = 1'b0;
        @(negedge clk);
        checkOutput("t5 ColOut after reset", {28'd0, kp.ColOut}, 32'hE);
        checkOutput("t5 key_held after reset", {31'd0, kp.key_held}, 32'd0);
        checkOutput("t5 key_valid after reset", {31'd0, kp.key_valid}, 32'd0);
        checkOutput("t5 key_code after reset", {28'd0, kp.key_code}, 32'd0);
        checkOutput("t5 strobes before reset", strobes, 0);
        repeat (2) @(negedge clk);
        applyStimulus(2, 2, 1'b0);
        nRST = 1'b1;
        measure(30, first, count, code_at, col_at, held_at);
        checkOutput("t5 strobes after reset", count, 0);

        // Key 0 (r3,c1) held for 100 cycles after acceptance.
        wait_col("t6 pre", 4'b0111);
        applyStimulus(3, 1, 1'b1);
        wait_col("t6 col c1", 4'b1101);
        first = -1; count = 0;
        for (int i = 0; i < 112; i++) begin
            if (kp.key_valid) begin
                if (first < 0) first = i;
                if (count < 8) begin
                    offs[count]  = i - first;
                    codes[count] = kp.key_code;
                end
                count++;
            end
            @(negedge clk);
        end
`ifdef KEYPAD_REPEAT_EN
        exp_n = 5;
        exp_offs[0] = 0; exp_offs[1] = 40; exp_offs[2] = 56; exp_offs[3] = 72; exp_offs[4] = 88;
`else
        exp_n = 1;
        exp_offs[0] = 0; exp_offs[1] = 0; exp_offs[2] = 0; exp_offs[3] = 0; exp_offs[4] = 0;
`endif
        checkOutput("t6 first strobe idx", first, 12);
        checkOutput("t6 strobe count", count, exp_n);
        for (int n = 0; n < exp_n && n < count; n++) begin
            checkOutput($sformatf("t6 strobe %0d offset", n), offs[n], exp_offs[n]);
            checkOutput($sformatf("t6 strobe %0d key_code", n), {28'd0, codes[n]}, 32'h0);
        end
        release_key("t6 release", 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
